// File: rtl/spi_cfg_loader.sv
// SPI mode-0 configuration loader for the SNN core: 16-bit frames write weights,
// thresholds, leak and enable registers; commit one clk after the 16th sampled edge.
// Optional readback of the addressed register on spi_cipo when SPI_READBACK_EN is defined.
module spi_cfg_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_copi,
  output logic        spi_cipo,
  output logic [71:0] weights,
  output logic [23:0] thresholds,
  output logic [7:0]  leak,
  output logic        core_en,
  output logic        cfg_wr
);

  localparam logic [6:0] LAST_ADDR = 7'd13;

  // synchronizer stages; index 0 is the flop nearest the pin
  logic [2:0]  sck_q;
  logic [1:0]  cs_n_q;
  logic [1:0]  copi_q;

  logic        sck_rise;
  logic        cs_n_s;
  logic        copi_s;

  logic [3:0]  bitcnt_q;
  logic [15:0] shift_q;
  logic [15:0] shift_d;
  logic        pend_q;
  logic [15:0] frame_q;

  logic [71:0] weights_q;
  logic [23:0] thresholds_q;
  logic [7:0]  leak_q;
  logic        core_en_q;
  logic        cfg_wr_q;

  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_n_s   = cs_n_q[1];
  assign copi_s   = copi_q[1];
  assign shift_d  = {shift_q[14:0], copi_s};
  assign wr_addr  = frame_q[14:8];
  assign wr_data  = frame_q[7:0];

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 3'b000;
      cs_n_q <= 2'b11;
      copi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_n_q <= {cs_n_q[0], spi_cs_n};
      copi_q <= {copi_q[0], spi_copi};
    end
  end

  // Shift in frame bits; a deselect at any point throws away the partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q <= 4'd0;
      shift_q  <= 16'd0;
      pend_q   <= 1'b0;
      frame_q  <= 16'd0;
    end else begin
      pend_q <= 1'b0;
      if (cs_n_s) begin
        bitcnt_q <= 4'd0;
        shift_q  <= 16'd0;
      end else if (sck_rise) begin
        shift_q  <= shift_d;
        bitcnt_q <= bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd15) begin
          pend_q  <= 1'b1;
          frame_q <= shift_d;
        end
      end
    end
  end

  // Commit a completed write frame to the register file and pulse cfg_wr
  always_ff @(posedge clk) begin
    if (rst) begin
      weights_q    <= 72'd0;
      thresholds_q <= 24'h101010;
      leak_q       <= 8'd0;
      core_en_q    <= 1'b0;
      cfg_wr_q     <= 1'b0;
    end else begin
      cfg_wr_q <= 1'b0;
      if (pend_q && frame_q[15] && (wr_addr <= LAST_ADDR)) begin
        cfg_wr_q <= 1'b1;
        for (int k = 0; k < 9; k++) begin
          if (wr_addr == 7'(k)) weights_q[8*k +: 8] <= wr_data;
        end
        for (int n = 0; n < 3; n++) begin
          if (wr_addr == 7'(9 + n)) thresholds_q[8*n +: 8] <= wr_data;
        end
        if (wr_addr == 7'd12) leak_q <= wr_data;
        if (wr_addr == 7'd13) core_en_q <= wr_data[0];
      end
    end
  end

  assign weights    = weights_q;
  assign thresholds = thresholds_q;
  assign leak       = leak_q;
  assign core_en    = core_en_q;
  assign cfg_wr     = cfg_wr_q;

`ifdef SPI_READBACK_EN
  logic       sck_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_val;
  logic [7:0] out_q;
  logic       cipo_q;
  logic       rd_act_q;

  assign sck_fall = ~sck_q[1] & sck_q[2];
  // address is complete once the 8th bit lands: first bit sits in shift_q[6]
  assign rd_addr  = {shift_q[5:0], copi_s};

  // Register file read mux; unmapped addresses read as zero
  always_comb begin
    rd_val = 8'd0;
    for (int k = 0; k < 9; k++) begin
      if (rd_addr == 7'(k)) rd_val = weights_q[8*k +: 8];
    end
    for (int n = 0; n < 3; n++) begin
      if (rd_addr == 7'(9 + n)) rd_val = thresholds_q[8*n +: 8];
    end
    if (rd_addr == 7'd12) rd_val = leak_q;
    if (rd_addr == 7'd13) rd_val = {7'd0, core_en_q};
  end

  // Load the shifter after the address phase, advance it on falls after edges 9..15
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= 8'd0;
      cipo_q   <= 1'b0;
      rd_act_q <= 1'b0;
    end else if (cs_n_s) begin
      out_q    <= 8'd0;
      cipo_q   <= 1'b0;
      rd_act_q <= 1'b0;
    end else if (sck_rise && (bitcnt_q == 4'd7) && !shift_q[6]) begin
      out_q    <= rd_val;
      cipo_q   <= rd_val[7];
      rd_act_q <= 1'b1;
    end else if (sck_fall && rd_act_q) begin
      if (bitcnt_q == 4'd0) begin
        rd_act_q <= 1'b0;
        cipo_q   <= 1'b0;
        out_q    <= 8'd0;
      end else if (bitcnt_q >= 4'd9) begin
        out_q  <= {out_q[6:0], 1'b0};
        cipo_q <= out_q[6];
      end
    end
  end

  assign spi_cipo = cipo_q;
`else
  assign spi_cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_loader.sv
// Directed bench for spi_cfg_loader: scoreboard of register snapshots popped on cfg_wr,
// plus hand-valued checks of reset, abort, back-to-back, out-of-range and readback.
// Readback expectations follow whether SPI_READBACK_EN is defined.
module tb_spi_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_copi;
  logic        spi_cipo;
  logic [71:0] weights;
  logic [23:0] thresholds;
  logic [7:0]  leak;
  logic        core_en;
  logic        cfg_wr;

  spi_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_copi   (spi_copi),
    .spi_cipo   (spi_cipo),
    .weights    (weights),
    .thresholds (thresholds),
    .leak       (leak),
    .core_en    (core_en),
    .cfg_wr     (cfg_wr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int n_exp_pulse = 0;
  logic cfg_prev = 1'b0;

  // model of the register file, updated when a write frame is issued
  logic [71:0] m_w = 72'd0;
  logic [23:0] m_t = 24'h101010;
  logic [7:0]  m_l = 8'd0;
  logic        m_en = 1'b0;
  logic [104:0] exp_q[$];

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_write(input logic [15:0] f);
    int a;
    a = int'(f[14:8]);
    if (f[15] && a <= 13) begin
      if (a <= 8) m_w[8*a +: 8] = f[7:0];
      else if (a <= 11) m_t[8*(a-9) +: 8] = f[7:0];
      else if (a == 12) m_l = f[7:0];
      else m_en = f[0];
      exp_q.push_back({m_w, m_t, m_l, m_en});
      n_exp_pulse++;
    end
  endtask

  // drive n bits of f MSB first, mode 0; collect cipo at sample edges 9..16
  task automatic send_bits(input logic [15:0] f, input int n, output logic [7:0] rb);
    rb = 8'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spi_copi = f[15-i];
      repeat (3) @(negedge clk);
      if (i >= 8) rb = {rb[6:0], spi_cipo};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] f, output logic [7:0] rb);
    model_write(f);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(f, 16, rb);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // scoreboard monitor: every cfg_wr pulse must match the oldest expected snapshot
  always @(negedge clk) begin
    if (!rst && cfg_wr) begin
      n_pulse++;
      check("cfg_wr_width", {71'd0, cfg_prev}, 72'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_cfg_wr: got pulse expected none");
      end else begin
        logic [104:0] e;
        e = exp_q.pop_front();
        check("sb_weights", weights, e[104:33]);
        check("sb_thresholds", {48'd0, thresholds}, {48'd0, e[32:9]});
        check("sb_leak", {64'd0, leak}, {64'd0, e[8:1]});
        check("sb_core_en", {71'd0, core_en}, {71'd0, e[0]});
      end
    end
    cfg_prev = cfg_wr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic [104:0] snap;
    logic [7:0] exp_rb;
    rst = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_copi = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_weights", weights, 72'd0);
    check("rst_thresholds", {48'd0, thresholds}, {48'd0, 24'h101010});
    check("rst_leak", {64'd0, leak}, 72'd0);
    check("rst_core_en", {71'd0, core_en}, 72'd0);
    check("rst_cfg_wr", {71'd0, cfg_wr}, 72'd0);
    check("rst_cipo", {71'd0, spi_cipo}, 72'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single write, addr 3
    frame(16'h8305, rb);
    check("wr_weights", weights, 72'h000000000005000000);
    check("wr_thresholds", {48'd0, thresholds}, {48'd0, 24'h101010});
    check("wr_leak", {64'd0, leak}, 72'd0);

    // abort after 10 bits, then the complete frame
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(16'h8D01, 10, rb);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_core_en", {71'd0, core_en}, 72'd0);
    frame(16'h8D01, rb);
    check("full_core_en", {71'd0, core_en}, 72'd1);

    // two frames back to back under one chip select
    model_write(16'h8C07);
    model_write(16'h8A20);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(16'h8C07, 16, rb);
    send_bits(16'h8A20, 16, rb);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("b2b_leak", {64'd0, leak}, 72'h07);
    check("b2b_thr1", {64'd0, thresholds[15:8]}, 72'h20);
    check("b2b_pulses", 72'(n_pulse), 72'd4);

    // out-of-range writes: top address and first unmapped address
    snap = {weights, thresholds, leak, core_en};
    frame(16'hFFAA, rb);
    frame(16'h8E33, rb);
    check("oor_state", {39'd0, weights, thresholds, leak, core_en} >> 33, {39'd0, snap} >> 33);
    check("oor_low", {39'd0, thresholds, leak, core_en}, {39'd0, snap[32:0]});

    // boundary addresses 0, 8, 11 with sign bit set
    frame(16'h8080, rb);
    frame(16'h8881, rb);
    frame(16'h8BFF, rb);
    check("bnd_weights", weights, 72'h810000000005000080);
    check("bnd_thresholds", {48'd0, thresholds}, {48'd0, 24'hFF2010});

    // readback
    frame(16'h8A5C, rb);
    frame(16'h0A00, rb);
`ifdef SPI_READBACK_EN
    exp_rb = 8'h5C;
`else
    exp_rb = 8'h00;
`endif
    check("rb_thr1", {64'd0, rb}, {64'd0, exp_rb});
    frame(16'h0D00, rb);
`ifdef SPI_READBACK_EN
    exp_rb = 8'h01;
`else
    exp_rb = 8'h00;
`endif
    check("rb_ctrl", {64'd0, rb}, {64'd0, exp_rb});
    frame(16'h0E00, rb);
    check("rb_unmapped", {64'd0, rb}, 72'd0);
    check("cipo_idle", {71'd0, spi_cipo}, 72'd0);
    check("rd_no_change", {64'd0, thresholds[15:8]}, 72'h5C);

    repeat (10) @(negedge clk);
    check("pulse_count", 72'(n_pulse), 72'(n_exp_pulse));
    check("sb_drained", 72'(exp_q.size()), 72'd0);
    check("final_weights", weights, m_w);
    check("final_misc", {39'd0, thresholds, leak, core_en}, {39'd0, m_t, m_l, m_en});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
